// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with peek, occupancy count, replace-top push+pop and sticky error flags.
// Pop data is registered with 1-cycle latency. There is no backpressure: a push while full is dropped, and a pop while empty is ignored; both set a flag.
module lifo_stack_param #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int               ADDR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W-1:0] top_addr;
    logic              empty_w, full_w;
    logic              ovf_set, unf_set;

    // Status and peek decode from registered state only.
    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CNT_DEPTH);
    assign top_addr = ADDR_W'(count_q - CNT_ONE);

    always_comb begin
        count_d     = count_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = ADDR_W'(count_q);
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        case ({push, pop})
            2'b10: begin
                if (!full_w) begin
                    wr_en_d = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_w) begin
                    data_out_d  = mem_q[top_addr];
                    out_valid_d = 1'b1;
                    count_d     = count_q - CNT_ONE;
                end else begin
                    unf_set = 1'b1;
                end
            end
            2'b11: begin
                out_valid_d = 1'b1;
                if (!empty_w) begin
                    // Replace-top: the old top leaves and the new word takes its slot.
                    data_out_d = mem_q[top_addr];
                    wr_en_d    = 1'b1;
                    wr_addr_d  = top_addr;
                end else begin
                    data_out_d = data_in;
                end
            end
            default: ;
        endcase

        overflow_d  = (overflow_q  & ~err_clr) | ovf_set;
        underflow_d = (underflow_q & ~err_clr) | unf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (wr_en_d) begin
                mem_q[wr_addr_d] <= data_in;
            end
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign top_data  = empty_w ? '0 : mem_q[top_addr];
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param: directed vectors, popped words checked by a queue-based monitor.
module tb_lifo_stack_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [DATA_W-1:0] top_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    lifo_stack_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .top_data  (top_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock with the given inputs; state is observable 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic ps, input logic pp,
                       input logic [DATA_W-1:0] din, input logic clr);
        reset   = rst;
        push    = ps;
        pop     = pp;
        data_in = din;
        err_clr = clr;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        err_clr = 1'b0;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        cyc(1'b0, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic do_pop(input logic [DATA_W-1:0] expect_word);
        exp_q.push_back(expect_word);
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    // Monitor: every out_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected out_valid", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                chk("popped data_out", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0; err_clr = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset top_data", top_data, 0);
        chk("reset data_out", data_out, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset flags", {overflow, underflow}, 0);

        // Basic LIFO order.
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        chk("t1 count", count, 3);
        chk("t1 top_data", top_data, 8'h33);
        do_pop(8'h33); do_pop(8'h22); do_pop(8'h11);
        chk("t1 empty", empty, 1);
        chk("t1 top_data empty", top_data, 0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < DEPTH; i++) do_push(8'hA0 + 8'(i));
        chk("t2 full", full, 1);
        chk("t2 count", count, DEPTH);
        do_push(8'hFF);
        chk("t2 count after ovf", count, DEPTH);
        chk("t2 overflow", overflow, 1);
        chk("t2 top_data", top_data, 8'hA7);
        for (int i = DEPTH - 1; i >= 0; i--) do_pop(8'hA0 + 8'(i));
        chk("t2 empty", empty, 1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t2 overflow cleared", overflow, 0);

        // Underflow and err_clr priority.
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b0);
        chk("t3 underflow", underflow, 1);
        chk("t3 out_valid", out_valid, 0);
        chk("t3 data_out held", data_out, 8'hA0);
        chk("t3 count", count, 0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t3 underflow cleared", underflow, 0);
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b1);
        chk("t3 set wins over clr", underflow, 1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t3 underflow cleared again", underflow, 0);

        // Replace-top.
        do_push(8'h01); do_push(8'h02);
        exp_q.push_back(8'h02);
        cyc(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        chk("t4 count", count, 2);
        chk("t4 top_data", top_data, 8'h55);
        do_pop(8'h55); do_pop(8'h01);
        for (int i = 0; i < DEPTH; i++) do_push(8'hB0 + 8'(i));
        exp_q.push_back(8'hB7);
        cyc(1'b0, 1'b1, 1'b1, 8'h66, 1'b0);
        chk("t4 full count", count, DEPTH);
        chk("t4 no overflow", overflow, 0);
        chk("t4 full top_data", top_data, 8'h66);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Pass-through on empty.
        exp_q.push_back(8'h7E);
        cyc(1'b0, 1'b1, 1'b1, 8'h7E, 1'b0);
        chk("t5 count", count, 0);
        chk("t5 flags", {overflow, underflow}, 0);
        chk("t5 empty", empty, 1);

        // Reset dominates a simultaneous pop.
        do_push(8'h12); do_push(8'h34); do_push(8'h56);
        cyc(1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("t6 count", count, 0);
        chk("t6 out_valid", out_valid, 0);
        chk("t6 data_out", data_out, 0);
        chk("t6 flags", {overflow, underflow}, 0);
        do_push(8'h44);
        chk("t6 top_data", top_data, 8'h44);
        chk("t6 count after push", count, 1);

        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
